multicycle_control: RTL

Main control finite state machine for the multi-cycle MIPS datapath. It sequences every instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode. It drives all datapath enables and mux selects, and it produces the 2-bit `ALUOp` consumed by `ALUDecoder`, which resolves `ALUOp` plus `Funct` into `ALUSel`. Outputs are Moore-style: decoded only from the current state, except `PCEn`, which also uses the ALU `Zero` flag.

---
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Each instruction is sequenced through fetch, decode, execute, memory and
// writeback steps chosen by the opcode. The outputs are Moore-style and depend
// only on the current state. The one exception is PCEn, which also uses the
// ALU Zero flag so that a taken beq can load the PC.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       PCEn,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;
    logic   pc_write;
    logic   branch;

    // State register: reset returns to FETCH, which aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: opcode dispatch in DECODE, lw/sw split in MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            // IR cannot change outside FETCH, so Op still holds the same memory opcode here.
            S_MEMADR: begin
                if (Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // Output decode from the current state. Reset shows the FETCH selects with all writes suppressed.
    always_comb begin
        MemtoReg = 1'b0;
        RegDst   = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        ALUOp    = 2'b00;
        IRWrite  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        pc_write = 1'b0;
        branch   = 1'b0;
        State    = state_q;
        case (state_q)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            // Precompute the branch target as PC + (SignImm << 2) while the opcode decodes.
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQEX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JEX: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
            end
        endcase
        if (reset) begin
            MemtoReg = 1'b0;
            RegDst   = 1'b0;
            IorD     = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b01;
            PCSrc    = 2'b00;
            ALUOp    = 2'b00;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            pc_write = 1'b0;
            branch   = 1'b0;
            State    = 4'd0;
        end
        PCEn = pc_write | (branch & Zero);
    end

endmodule
